// File: rtl/nco_test_source.sv
// Phase-accumulator square-wave source with glitch-free word switching at wrap,
// plus a free-running gate that counts clock_out rising edges per window.
module nco_test_source #(
    parameter int ACC_WIDTH = 32,
    parameter int GATE_LOG2 = 27
) (
    input  logic                 clock,
    input  logic                 resetb,
    input  logic                 enable,
    input  logic [ACC_WIDTH-1:0] tuning_word,
    input  logic                 load,
    output logic                 load_ack,
    output logic                 clock_out,
    output logic                 gate,
    output logic [31:0]          edge_count,
    output logic                 result_valid,
    output logic [15:0]          gate_number
);

    typedef enum logic [1:0] {IDLE, RUN, PENDING} state_t;

    localparam logic [GATE_LOG2:0] GATE_ONE = {{GATE_LOG2{1'b0}}, 1'b1};

    state_t               state, state_nxt;
    logic [ACC_WIDTH-1:0] acc, acc_nxt;
    logic [ACC_WIDTH-1:0] active_word, active_nxt;
    logic [ACC_WIDTH-1:0] pending_word, pending_nxt;
    logic [ACC_WIDTH:0]   sum;
    logic                 wrap;
    logic                 ack_nxt;
    logic                 run_ok;

    logic [GATE_LOG2:0]   gate_cnt;
    logic                 gate_d;
    logic                 clock_out_d;
    logic [31:0]          edge_acc;
    logic                 rise;
    logic                 gate_fell;

    // Reset is asserted asynchronously but released on a clock edge; logic
    // starts updating on the second rising edge after resetb goes high.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) run_ok <= 1'b0;
        else         run_ok <= 1'b1;
    end

    assign sum  = {1'b0, acc} + {1'b0, active_word};
    assign wrap = sum[ACC_WIDTH];

    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        active_nxt  = active_word;
        pending_nxt = pending_word;
        ack_nxt     = 1'b0;
        case (state)
            IDLE: begin
                acc_nxt = '0;
                if (load) begin
                    active_nxt = tuning_word;
                    ack_nxt    = 1'b1;
                end
                if (enable) state_nxt = RUN;
            end
            RUN: begin
                acc_nxt = sum[ACC_WIDTH-1:0];
                if (load) begin
                    pending_nxt = tuning_word;
                    state_nxt   = PENDING;
                end
            end
            PENDING: begin
                acc_nxt = sum[ACC_WIDTH-1:0];
                // A load landing on the wrap itself is the newest word, so it wins.
                if (wrap) begin
                    active_nxt = load ? tuning_word : pending_word;
                    ack_nxt    = 1'b1;
                    state_nxt  = RUN;
                end else if (load) begin
                    pending_nxt = tuning_word;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!enable && state != IDLE) begin
            state_nxt   = IDLE;
            acc_nxt     = '0;
            active_nxt  = active_word;
            pending_nxt = '0;
            ack_nxt     = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state        <= IDLE;
            acc          <= '0;
            active_word  <= '0;
            pending_word <= '0;
            load_ack     <= 1'b0;
            clock_out    <= 1'b0;
        end else if (run_ok) begin
            state        <= state_nxt;
            acc          <= acc_nxt;
            active_word  <= active_nxt;
            pending_word <= pending_nxt;
            load_ack     <= ack_nxt;
            clock_out    <= acc_nxt[ACC_WIDTH-1];
        end
    end

    assign gate      = gate_cnt[GATE_LOG2];
    assign rise      = clock_out & ~clock_out_d;
    assign gate_fell = gate_d & ~gate;

    // Edges are only counted while gate is high, so a rise in the first
    // low cycle is ignored.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            gate_cnt     <= '0;
            gate_d       <= 1'b0;
            clock_out_d  <= 1'b0;
            edge_acc     <= '0;
            edge_count   <= '0;
            result_valid <= 1'b0;
            gate_number  <= '0;
        end else if (run_ok) begin
            gate_cnt     <= gate_cnt + GATE_ONE;
            gate_d       <= gate;
            clock_out_d  <= clock_out;
            result_valid <= gate_fell;
            if (gate_fell) begin
                edge_count  <= edge_acc;
                gate_number <= gate_number + 16'd1;
                edge_acc    <= '0;
            end else if (gate && rise && edge_acc != 32'hFFFF_FFFF) begin
                edge_acc <= edge_acc + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_nco_test_source.sv
// Directed bench for nco_test_source (ACC_WIDTH=32, GATE_LOG2=4) with a
// queue of expected edge counts and a bench-side accumulator model.
module tb_nco_test_source;

    logic        clock;
    logic        resetb;
    logic        enable;
    logic [31:0] tuning_word;
    logic        load;
    logic        load_ack;
    logic        clock_out;
    logic        gate;
    logic [31:0] edge_count;
    logic        result_valid;
    logic [15:0] gate_number;

    nco_test_source #(.ACC_WIDTH(32), .GATE_LOG2(4)) dut (
        .clock(clock), .resetb(resetb), .enable(enable), .tuning_word(tuning_word),
        .load(load), .load_ack(load_ack), .clock_out(clock_out), .gate(gate),
        .edge_count(edge_count), .result_valid(result_valid), .gate_number(gate_number)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];   // expected edge_count per result, -1 = partial window
    bit clk_q[$];   // expected clock_out per cycle

    int          cyc = 0;
    int          ack_cnt = 0;
    int          rv_cnt = 0;
    int          last_cyc = 0;
    logic [31:0] last_ec = '0;
    logic [15:0] last_gn = '0;

    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (load_ack === 1'b1) ack_cnt <= ack_cnt + 1;
        if (result_valid === 1'b1) begin
            rv_cnt   <= rv_cnt + 1;
            last_ec  <= edge_count;
            last_gn  <= gate_number;
            last_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_rv(input string tag);
        int start;
        int n;
        int exp_v;
        bit got;
        start = rv_cnt;
        n = 0;
        while (rv_cnt == start && n < 80) begin
            step();
            n++;
        end
        got = (rv_cnt != start);
        exp_v = -1;
        if (exp_q.size() > 0) exp_v = exp_q.pop_front();
        if (!got) check({tag, "_timeout"}, 64'(got), 64'd1);
        else if (exp_v >= 0) check(tag, 64'(last_ec), 64'(exp_v));
    endtask

    task automatic wait_rise(input string tag);
        logic p;
        int n;
        bit found;
        n = 0;
        found = 1'b0;
        while (!found && n < 40) begin
            p = clock_out;
            step();
            n++;
            found = (clock_out === 1'b1 && p === 1'b0);
        end
        if (!found) check({tag, "_timeout"}, 64'(found), 64'd1);
    endtask

    task automatic wait_ack(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (load_ack !== 1'b1 && n < max_cyc) begin
            step();
            n++;
        end
        check(tag, 64'(load_ack), 64'd1);
    endtask

    task automatic run_model(input string tag, input logic [31:0] start_acc,
                             input logic [31:0] w, input int n);
        logic [31:0] a;
        bit e;
        a = start_acc;
        for (int i = 0; i < n; i++) begin
            a = a + w;
            clk_q.push_back(a[31]);
        end
        for (int i = 0; i < n; i++) begin
            step();
            e = clk_q.pop_front();
            check(tag, 64'(clock_out), 64'(e));
        end
    endtask

    initial begin
        int          a0;
        int          c1;
        logic [15:0] g1;
        logic        cv;
        bit          changed;
        int          n;

        resetb = 1'b0; enable = 1'b0; load = 1'b0; tuning_word = '0;
        repeat (3) step();
        check("reset_outputs", {load_ack, clock_out, gate, result_valid, edge_count, gate_number}, '0);

        // Release between edges; gate counter starts on the second edge.
        resetb = 1'b1;
        repeat (16) step();
        check("gate_low_first_half", 64'(gate), 64'd0);
        step();
        check("gate_rise_at_17", 64'(gate), 64'd1);

        // IDLE load, then run at quarter rate.
        tuning_word = 32'h4000_0000; load = 1'b1;
        step();
        load = 1'b0;
        check("idle_load_ack", 64'(load_ack), 64'd1);
        step();
        check("idle_ack_single", 64'(load_ack), 64'd0);
        check("idle_clock_out", 64'(clock_out), 64'd0);
        enable = 1'b1;
        wait_rise("p4_rise");
        run_model("p4_wave", 32'h8000_0000, 32'h4000_0000, 8);
        exp_q.push_back(-1); exp_q.push_back(4); exp_q.push_back(4);
        wait_rv("p4_count_a");
        wait_rv("p4_count_b");
        g1 = last_gn; c1 = last_cyc;
        wait_rv("p4_count_c");
        check("gate_number_step", 64'(last_gn - g1), 64'd1);
        check("gate_period", 64'(last_cyc - c1), 64'd32);

        // Phase-continuous switch to eighth rate at the next wrap.
        wait_rise("p8_rise");
        a0 = ack_cnt;
        tuning_word = 32'h2000_0000; load = 1'b1;
        step();
        load = 1'b0;
        check("pend_no_early_ack", 64'(load_ack), 64'd0);
        step();
        check("ack_at_wrap", 64'(load_ack), 64'd1);
        check("clock_at_wrap", 64'(clock_out), 64'd0);
        run_model("p8_wave", 32'h0, 32'h2000_0000, 16);
        exp_q.push_back(-1); exp_q.push_back(2);
        wait_rv("p8_count_a");
        wait_rv("p8_count_b");
        check("p8_single_ack", 64'(ack_cnt - a0), 64'd1);

        // Two loads before the wrap: only the latest applies, one ack.
        wait_rise("dbl_rise");
        a0 = ack_cnt;
        tuning_word = 32'h1000_0000; load = 1'b1;
        step();
        tuning_word = 32'h8000_0000;
        step();
        load = 1'b0;
        wait_ack("dbl_ack", 6);
        run_model("p2_wave", 32'h0, 32'h8000_0000, 8);
        exp_q.push_back(-1); exp_q.push_back(8);
        wait_rv("p2_count_a");
        wait_rv("p2_count_b");
        check("dbl_single_ack", 64'(ack_cnt - a0), 64'd1);

        // Word 0 applied, then a further load can never see a wrap.
        tuning_word = 32'h0; load = 1'b1;
        step();
        load = 1'b0;
        wait_ack("zero_ack", 6);
        step();
        tuning_word = 32'h4000_0000; load = 1'b1;
        step();
        load = 1'b0;
        a0 = ack_cnt;
        cv = clock_out;
        changed = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (clock_out !== cv) changed = 1'b1;
        end
        check("zero_frozen", 64'(changed), 64'd0);
        exp_q.push_back(-1); exp_q.push_back(0);
        wait_rv("zero_count_a");
        wait_rv("zero_count_b");
        check("zero_pending_no_ack", 64'(ack_cnt - a0), 64'd0);
        enable = 1'b0;
        step();
        check("idle_clock_zero", 64'(clock_out), 64'd0);
        enable = 1'b1;
        repeat (40) step();
        check("discarded_no_ack", 64'(ack_cnt - a0), 64'd0);

        // Reset mid-gate with a word pending.
        enable = 1'b0;
        step();
        tuning_word = 32'h4000_0000; load = 1'b1;
        step();
        load = 1'b0; enable = 1'b1;
        n = 0;
        while (gate !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        repeat (3) step();
        tuning_word = 32'h2000_0000; load = 1'b1;
        step();
        load = 1'b0;
        a0 = ack_cnt;
        resetb = 1'b0;
        #1;
        check("midrst_outputs", {load_ack, clock_out, gate, result_valid, edge_count, gate_number}, '0);
        c1 = rv_cnt;
        repeat (5) step();
        check("midrst_no_rv", 64'(rv_cnt - c1), 64'd0);
        resetb = 1'b1;
        exp_q.push_back(0);
        n = 0;
        while (result_valid !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        check("post_rst_rv_latency", 64'(n), 64'd34);
        check("post_rst_gate_number", 64'(gate_number), 64'd1);
        check("post_rst_edge_count", 64'(edge_count), 64'(exp_q.pop_front()));
        check("post_rst_no_ack", 64'(ack_cnt - a0), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
